// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline: operand forwarding, load-use stall, redirect flush, dmem wait.
// Latency: forwarding and stall/bubble/flush controls are combinational (same cycle); FSM, error flag and counters are registered.
// Backpressure: dmem_req && !dmem_ready freezes PC..EX/MEM and bubbles MEM/WB until the memory returns ready.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   id_rs1/id_rs2            IF/ID source registers
//   ex_rs1/ex_rs2/ex_rd      ID/EX source and destination registers, ex_mem_read = ID/EX is a load
//   mem_rd/mem_reg_write     EX/MEM destination and write enable
//   wb_rd/wb_reg_write       MEM/WB destination and write enable
//   mem_redirect             control transfer resolved in MEM
//   dmem_req/dmem_ready      data memory access handshake of the MEM-stage instruction
//   fwd_a/fwd_b              EX operand select: 00 reg file, 01 MEM/WB, 10 EX/MEM
//   *_stall/*_bubble/*_flush pipeline register controls
//   in_mem_wait              FSM is in MEM_WAIT
//   mem_timeout_err          sticky, memory wait reached MEM_TIMEOUT cycles
//   stall_cnt/flush_cnt      saturating performance counters
module hazard_ctrl_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             mem_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             in_mem_wait,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [15:0]      TIMEOUT_V = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        dmem_wait;
  logic        load_use;

  // Forwarding: the younger result in EX/MEM wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1)      fwd_a = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)    fwd_a = 2'b01;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2)      fwd_b = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)    fwd_b = 2'b01;
  end

  assign dmem_wait = dmem_req && !dmem_ready;
  assign load_use  = ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);

  // Pipeline controls. Memory wait freezes everything (a redirect in MEM must wait for
  // its own instruction to leave), redirect kills younger work so load-use is moot.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    if (!rst) begin
      if (dmem_wait) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (mem_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // wait_cnt counts every stalled memory cycle including the one that enters MEM_WAIT,
  // so the error rises on the edge that ends the MEM_TIMEOUT-th wait cycle.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = 16'd0;
    if (dmem_wait)
      wait_cnt_nxt = (wait_cnt == TIMEOUT_V) ? wait_cnt : wait_cnt + 16'd1;
    case (state)
      RUN:      if (dmem_wait)  state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ready) state_nxt = RUN;
      default:                  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      wait_cnt        <= 16'd0;
      mem_timeout_err <= 1'b0;
      stall_cnt       <= '0;
      flush_cnt       <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt == TIMEOUT_V)
        mem_timeout_err <= 1'b1;
      if (pc_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_ONE;
      // if_id_flush is high exactly when a redirect is applied (not blocked by wait)
      if (if_id_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign in_mem_wait = (state == MEM_WAIT);

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_mem_read, mem_reg_write, wb_reg_write, mem_redirect, dmem_req, dmem_ready;
  logic [1:0] fwd_a, fwd_b;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble, mem_wb_bubble;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, in_mem_wait, mem_timeout_err;
  logic [2:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  hazard_ctrl_unit #(.CNT_W(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .mem_redirect(mem_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .in_mem_wait(in_mem_wait), .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc, if_id, id_ex, ex_mem stall, id_ex_bubble, mem_wb_bubble, if_id, id_ex, ex_mem flush}
  localparam logic [8:0] C_NONE  = 9'b000000000;
  localparam logic [8:0] C_LU    = 9'b110010000;
  localparam logic [8:0] C_FLUSH = 9'b000000111;
  localparam logic [8:0] C_WAIT  = 9'b111101000;

  logic [8:0] ctrl;
  assign ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
                 mem_wb_bubble, if_id_flush, id_ex_flush, ex_mem_flush};

  typedef struct {
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic       ex_mem_read;
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    logic [4:0] wb_rd;
    logic       wb_reg_write;
    logic       mem_redirect;
    logic [1:0] exp_a, exp_b;
    logic [8:0] exp_ctrl;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen before the falling edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0; mem_redirect = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick;
  endtask

  // Deasserting dmem_req while waiting for memory is an illegal stimulus.
  always @(negedge clk) begin
    if (!rst && in_mem_wait && !dmem_req) begin
      errors++;
      $display("FAIL dmem_req_drop: dmem_req=0 while in_mem_wait=1 (t=%0t)", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 2'b10, 2'b00, C_NONE};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 2'b01, 2'b00, C_NONE};
    vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
    vecs[3]  = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 2'b10, 2'b10, C_NONE};
    vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00, C_NONE};
    vecs[5]  = '{5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 2'b10, 2'b01, C_NONE};
    vecs[6]  = '{5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 2'b01, 2'b00, C_NONE};
    vecs[7]  = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, C_LU};
    vecs[8]  = '{5'd7, 5'd2, 5'd0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, C_LU};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
    vecs[10] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
    vecs[11] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00, C_FLUSH};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00, C_FLUSH};

    // Reset state, with a pending memory wait that must not leak through.
    idle;
    rst = 1'b1;
    dmem_req = 1'b1;
    tick;
    tick;
    #1;
    chk("reset_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("reset_in_mem_wait", 32'(in_mem_wait), 0);
    chk("reset_err", 32'(mem_timeout_err), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);
    dmem_req = 1'b0;
    rst = 1'b0;
    tick;

    // Forwarding, load-use and redirect table.
    for (int i = 0; i < 13; i++) begin
      id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2;
      ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2; ex_rd = vecs[i].ex_rd;
      ex_mem_read = vecs[i].ex_mem_read;
      mem_rd = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_reg_write;
      wb_rd = vecs[i].wb_rd; wb_reg_write = vecs[i].wb_reg_write;
      mem_redirect = vecs[i].mem_redirect;
      dmem_req = 1'b0; dmem_ready = 1'b0;
      #2;
      chk($sformatf("vec%0d_fwd_a", i), 32'(fwd_a), 32'(vecs[i].exp_a));
      chk($sformatf("vec%0d_fwd_b", i), 32'(fwd_b), 32'(vecs[i].exp_b));
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
      tick;
    end
    idle;
    #1;
    chk("table_stall_cnt", 32'(stall_cnt), 2);
    chk("table_flush_cnt", 32'(flush_cnt), 2);

    // Three wait cycles then ready; a redirect during the wait is not applied.
    pulse_reset;
    for (int i = 0; i < 3; i++) begin
      dmem_req = 1'b1; dmem_ready = 1'b0; mem_redirect = 1'b1;
      #2;
      chk($sformatf("wait%0d_ctrl", i), 32'(ctrl), 32'(C_WAIT));
      chk($sformatf("wait%0d_in_mem_wait", i), 32'(in_mem_wait), (i > 0) ? 1 : 0);
      tick;
    end
    dmem_ready = 1'b1; mem_redirect = 1'b0;
    #2;
    chk("ready_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("ready_in_mem_wait", 32'(in_mem_wait), 1);
    tick;
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("after_wait_in_mem_wait", 32'(in_mem_wait), 0);
    chk("after_wait_stall_cnt", 32'(stall_cnt), 3);
    chk("after_wait_flush_cnt", 32'(flush_cnt), 0);

    // Timeout after the 4th wait cycle, sticky through ready, cleared by async reset.
    pulse_reset;
    for (int i = 1; i <= 6; i++) begin
      dmem_req = 1'b1; dmem_ready = 1'b0;
      tick;
      chk($sformatf("timeout_err_c%0d", i), 32'(mem_timeout_err), (i >= 4) ? 1 : 0);
    end
    dmem_ready = 1'b1;
    tick;
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("timeout_err_after_ready", 32'(mem_timeout_err), 1);
    chk("timeout_in_mem_wait", 32'(in_mem_wait), 0);
    chk("timeout_stall_cnt", 32'(stall_cnt), 6);
    dmem_req = 1'b1;
    tick;
    tick;
    chk("midwait_in_mem_wait", 32'(in_mem_wait), 1);
    chk("stall_cnt_sat_wait", 32'(stall_cnt), 7);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_in_mem_wait", 32'(in_mem_wait), 0);
    chk("async_rst_err", 32'(mem_timeout_err), 0);
    chk("async_rst_stall_cnt", 32'(stall_cnt), 0);
    chk("async_rst_ctrl", 32'(ctrl), 32'(C_NONE));
    dmem_req = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    // Continuous load-use stalls saturate the 3-bit counter at 7.
    pulse_reset;
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk($sformatf("lu_pc_stall_c%0d", i), 32'(pc_stall), 1);
      tick;
      chk($sformatf("lu_stall_cnt_c%0d", i), 32'(stall_cnt), (i < 7) ? i : 7);
    end
    idle;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
